// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the byte-serial program loader.
// The state enum and memory geometry are kept here so the bench and sub-module agree.
package prog_loader_pkg;

  localparam int PMEM_DEPTH     = 32;
  localparam int PMEM_AW        = 5;
  localparam int INSTR_W        = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_WRITE,
    ST_CHECK,
    ST_DONE
  } ldr_state_t;

  // A load request is legal only for 1..PMEM_DEPTH words.
  function automatic logic nwords_ok(input logic [5:0] n);
    return (n != 6'd0) && (n <= 6'(PMEM_DEPTH));
  endfunction

endpackage

// File: rtl/prog_word_asm.sv
// Big-endian word assembler: shifts bytes into a word, counts bytes per word
// and keeps the running XOR checksum of every byte loaded since the last clear.
module prog_word_asm
  import prog_loader_pkg::*;
#(
  parameter int DW = INSTR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          clear,
  input  logic [7:0]    data,
  output logic [DW-1:0] word,
  output logic          last_byte,
  output logic [7:0]    csum
);

  logic [DW-1:0] shreg;
  logic [1:0]    byte_cnt;
  logic [7:0]    csum_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= '0;
      byte_cnt <= '0;
      csum_q   <= '0;
    end else if (clear) begin
      shreg    <= '0;
      byte_cnt <= '0;
      csum_q   <= '0;
    end else if (load) begin
      shreg    <= {shreg[DW-9:0], data};
      csum_q   <= csum_q ^ data;
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

  assign word      = shreg;
  assign last_byte = (byte_cnt == 2'(BYTES_PER_WORD - 1));
  assign csum      = csum_q;

endmodule

// File: rtl/prog_loader.sv
// Program loader: streams bytes into instruction memory word by word, checks a
// trailing XOR checksum and holds the core in reset for the duration of the load.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DEPTH = PMEM_DEPTH,
  parameter int AW    = PMEM_AW,
  parameter int DW    = INSTR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [5:0]    nwords,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          err
);

  ldr_state_t    state;
  logic [5:0]    nwords_q;
  logic [AW-1:0] word_cnt;
  logic          err_q;

  logic          xfer;
  logic          start_ok;
  logic          last_word;
  logic          asm_load;
  logic          asm_clear;
  logic [DW-1:0] asm_word;
  logic          asm_last_byte;
  logic [7:0]    asm_csum;

  // All outputs are decoded from registers only, so no input reaches an output combinationally.
  assign byte_ready = (state == ST_RECV) || (state == ST_CHECK);
  assign mem_we     = (state == ST_WRITE);
  assign busy       = (state == ST_RECV) || (state == ST_WRITE) || (state == ST_CHECK);
  assign cpu_hold   = busy;
  assign done       = (state == ST_DONE);
  assign err        = err_q;
  assign mem_addr   = word_cnt;
  assign mem_wdata  = asm_word;

  assign xfer      = byte_valid && byte_ready;
  assign start_ok  = (state == ST_IDLE) && start && nwords_ok(nwords);
  assign last_word = (6'(word_cnt) == (nwords_q - 6'd1));
  assign asm_load  = xfer && (state == ST_RECV);
  assign asm_clear = start_ok;

  prog_word_asm #(.DW(DW)) u_word_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (asm_load),
    .clear     (asm_clear),
    .data      (byte_data),
    .word      (asm_word),
    .last_byte (asm_last_byte),
    .csum      (asm_csum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      nwords_q <= '0;
      word_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (nwords_ok(nwords)) begin
              nwords_q <= nwords;
              word_cnt <= '0;
              err_q    <= 1'b0;
              state    <= ST_RECV;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_RECV: begin
          if (xfer && asm_last_byte) state <= ST_WRITE;
        end
        ST_WRITE: begin
          if (last_word) begin
            state <= ST_CHECK;
          end else begin
            word_cnt <= word_cnt + 1'b1;
            state    <= ST_RECV;
          end
        end
        ST_CHECK: begin
          // Memory is left as written even when the checksum disagrees.
          if (xfer) begin
            err_q <= (byte_data != asm_csum);
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: expected memory writes are queued as
// bytes are driven and compared whenever the loader strobes mem_we.
`timescale 1ns/1ps
module tb_prog_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [5:0]  nwords;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_wr_t;

  exp_wr_t exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  prog_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .nwords     (nwords),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Write monitor / scoreboard consumer.
  always @(negedge clk) begin : mon
    exp_wr_t e;
    if (rst_n && mem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e.addr));
        check("wr_data", mem_wdata, e.data);
      end
      check("ready_in_write", 32'(byte_ready), 32'd0);
    end
  end

  // Called at a negedge; returns at a negedge.
  task automatic do_start(input logic [5:0] n);
    start  = 1'b1;
    nwords = n;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit noise);
    int n;
    for (int g = 0; g < gap; g++) begin
      if (noise) begin
        start  = 1'b1;
        nwords = 6'd3;
      end
      @(negedge clk);
      start = 1'b0;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    while (!byte_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("byte_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
    byte_data  = 8'h00;
  endtask

  task automatic do_load(input int nw, input logic [31:0] w[32], input logic [7:0] cs,
                         input logic exp_err, input int max_gap, input bit noise);
    for (int i = 0; i < nw; i++) exp_q.push_back('{addr: 5'(i), data: w[i]});
    do_start(6'(nw));
    check("ready_after_start", 32'(byte_ready), 32'd1);
    check("err_cleared_on_start", 32'(err), 32'd0);
    check("hold_during_load", 32'(cpu_hold), 32'd1);
    for (int i = 0; i < nw; i++)
      for (int b = 0; b < 4; b++)
        send_byte(w[i][31-8*b -: 8], noise ? 1 : int'($urandom_range(max_gap, 0)), noise);
    send_byte(cs, 0, 1'b0);
    check("done_pulse", 32'(done), 32'd1);
    check("err_after_check", 32'(err), 32'(exp_err));
    check("hold_drops_in_done", 32'(cpu_hold), 32'd0);
    check("busy_drops_in_done", 32'(busy), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_we"},    32'(mem_we),     32'd0);
    check({tag, "_addr"},  32'(mem_addr),   32'd0);
    check({tag, "_wdata"}, mem_wdata,       32'd0);
    check({tag, "_hold"},  32'(cpu_hold),   32'd0);
    check({tag, "_busy"},  32'(busy),       32'd0);
    check({tag, "_done"},  32'(done),       32'd0);
    check({tag, "_err"},   32'(err),        32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [31:0] w[32];
    logic [7:0]  cs;

    rst_n = 1'b0; start = 1'b0; nwords = '0; byte_valid = 1'b0; byte_data = '0;
    foreach (w[i]) w[i] = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic two-word load with correct checksum.
    w[0] = 32'h8040_0001;
    w[1] = 32'h8080_0002;
    do_load(2, w, 8'hC3, 1'b0, 0, 1'b0);

    // Same stream, wrong checksum: writes still happen, err latches.
    do_load(2, w, 8'h00, 1'b1, 0, 1'b0);
    repeat (2) @(negedge clk);
    check("err_sticky", 32'(err), 32'd1);

    // Illegal word counts are rejected without leaving IDLE.
    do_start(6'd0);
    check("nw0_err", 32'(err), 32'd1);
    check("nw0_busy", 32'(busy), 32'd0);
    check("nw0_ready", 32'(byte_ready), 32'd0);
    do_start(6'd33);
    repeat (3) @(negedge clk);
    check("nw33_err", 32'(err), 32'd1);
    check("nw33_busy", 32'(busy), 32'd0);
    check("nw33_ready", 32'(byte_ready), 32'd0);

    // Random stalls between bytes.
    do_load(2, w, 8'hC3, 1'b0, 5, 1'b0);

    // Reset in the middle of word 0.
    do_start(6'd2);
    send_byte(8'h80, 0, 1'b0);
    send_byte(8'h40, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midload_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    w[0] = 32'h0000_002A;
    do_load(1, w, 8'h2A, 1'b0, 0, 1'b0);

    // Full 32-word load with start pulses sprinkled in the byte gaps.
    cs = 8'h00;
    for (int i = 0; i < 32; i++) begin
      w[i] = 32'h0100_0000 + 32'(i);
      cs = cs ^ w[i][31:24] ^ w[i][23:16] ^ w[i][15:8] ^ w[i][7:0];
    end
    do_load(32, w, cs, 1'b0, 0, 1'b1);

    repeat (3) @(negedge clk);
    check("idle_at_end_busy", 32'(busy), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
